// File: rtl/mgt01_alu_issue_pkg.sv
// rtl/mgt01_alu_issue_pkg.sv - shared opcodes, ALU op encoding and writeback bundle for the issue stage
package mgt01_alu_issue_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND,
        ALU_SLL, ALU_SRL, ALU_SRA,
        ALU_EQ, ALU_NE, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU,
        ALU_BMSK
    } alu_ops_e;

    typedef union packed {
        logic [XLEN-1:0]        u;
        logic signed [XLEN-1:0] s;
    } data_u;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} issue_state_e;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [4:0]      rd;
        logic            wr_en;
        logic            taken;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] csr_wdata;
        logic            csr_we;
        logic            illegal;
    } wb_bundle_t;

    // Shift amounts only ever use the low five bits of the operand.
    function automatic logic [XLEN-1:0] shamt(input logic [XLEN-1:0] v);
        return {{(XLEN-5){1'b0}}, v[4:0]};
    endfunction

endpackage

// File: rtl/mgt01_issue_skid.sv
// rtl/mgt01_issue_skid.sv - generic 2-entry valid/ready output register with skid slot
module mgt01_issue_skid
    import mgt01_alu_issue_pkg::*;
#(
    parameter type T = wb_bundle_t
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    issue_state_e state, state_next;
    T             out_q, skid_q;
    logic         accept, take;
    logic         load_in, load_skid, pop_skid;

    assign in_ready  = (state != FULL) && !rst;
    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = (state != EMPTY);
    assign take      = out_valid && out_ready;
    assign out_data  = out_q;

    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_in    = 1'b0;
        load_skid  = 1'b0;
        pop_skid   = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    state_next = ONE;
                    load_in    = 1'b1;
                end
                ONE: begin
                    if (accept && !take) begin
                        state_next = FULL;
                        load_skid  = 1'b1;
                    end else if (take && !accept) begin
                        state_next = EMPTY;
                    end else if (take && accept) begin
                        load_in = 1'b1;
                    end
                end
                FULL: if (take) begin
                    state_next = ONE;
                    pop_skid   = 1'b1;
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    // Data is cleared on reset and flush so a dropped entry never lingers on the outputs.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_in)       out_q <= in_data;
            else if (pop_skid) out_q <= skid_q;
            if (load_skid)     skid_q <= in_data;
        end
    end

endmodule

// File: rtl/mgt01_alu_issue.sv
// rtl/mgt01_alu_issue.sv - execute issue/writeback sequencer; CSR decode enabled by MGT01_ISSUE_CSR_EN
module mgt01_alu_issue
    import mgt01_alu_issue_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [6:0]      opcode_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] csr_data_i,
    input  logic [4:0]      rd_addr_i,
    output data_u           alu_op_A_o,
    output data_u           alu_op_B_o,
    output alu_ops_e        alu_ops_o,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic            alu_comparison_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_addr_o,
    output logic            wr_en_o,
    output logic            branch_taken_o,
    output logic [XLEN-1:0] branch_target_o,
    output logic [XLEN-1:0] csr_wdata_o,
    output logic            csr_we_o,
    output logic            illegal_o
);

    logic [XLEN-1:0] op_a, op_b;
    alu_ops_e        alu_op;
    logic            legal, writes_rd, is_jump, is_branch, use_cmp, is_csr;
    logic [XLEN-1:0] tgt_base, tgt_sum;
    wb_bundle_t      wb_in, wb_out;
    logic            out_valid;
`ifdef MGT01_ISSUE_CSR_EN
    logic            csr_direct;
    logic [XLEN-1:0] csr_src;

    assign csr_src = funct3_i[2] ? {{(XLEN-5){1'b0}}, imm_i[4:0]} : rs1_data_i;
`endif

    always_comb begin
        op_a      = '0;
        op_b      = '0;
        alu_op    = ALU_ADD;
        legal     = 1'b0;
        writes_rd = 1'b0;
        is_jump   = 1'b0;
        is_branch = 1'b0;
        use_cmp   = 1'b0;
        is_csr    = 1'b0;
`ifdef MGT01_ISSUE_CSR_EN
        csr_direct = 1'b0;
`endif
        if (valid_i) begin
            case (opcode_i)
                OPC_OP, OPC_OP_IMM: begin
                    op_a      = rs1_data_i;
                    op_b      = (opcode_i == OPC_OP) ? rs2_data_i : imm_i;
                    writes_rd = 1'b1;
                    case (funct3_i)
                        3'b000: alu_op = (opcode_i == OPC_OP && funct7_i[5]) ? ALU_SUB : ALU_ADD;
                        3'b001: begin alu_op = ALU_SLL; op_b = shamt(op_b); end
                        3'b010: begin alu_op = ALU_LT;  use_cmp = 1'b1; end
                        3'b011: begin alu_op = ALU_LTU; use_cmp = 1'b1; end
                        3'b100: alu_op = ALU_XOR;
                        3'b101: begin alu_op = funct7_i[5] ? ALU_SRA : ALU_SRL; op_b = shamt(op_b); end
                        3'b110: alu_op = ALU_OR;
                        default: alu_op = ALU_AND;
                    endcase
                    // OP-IMM immediates overlap funct7 except on shifts.
                    if (opcode_i == OPC_OP)
                        legal = (funct7_i == 7'b0000000) ||
                                (funct7_i == 7'b0100000 && (funct3_i == 3'b000 || funct3_i == 3'b101));
                    else if (funct3_i == 3'b001)
                        legal = (funct7_i == 7'b0000000);
                    else if (funct3_i == 3'b101)
                        legal = (funct7_i == 7'b0000000) || (funct7_i == 7'b0100000);
                    else
                        legal = 1'b1;
                end
                OPC_LUI: begin
                    op_b      = imm_i;
                    legal     = 1'b1;
                    writes_rd = 1'b1;
                end
                OPC_AUIPC: begin
                    op_a      = pc_i;
                    op_b      = imm_i;
                    legal     = 1'b1;
                    writes_rd = 1'b1;
                end
                OPC_JAL, OPC_JALR: begin
                    op_a      = pc_i;
                    op_b      = 32'd4;
                    is_jump   = 1'b1;
                    writes_rd = 1'b1;
                    legal     = (opcode_i == OPC_JAL) || (funct3_i == 3'b000);
                end
                OPC_BRANCH: begin
                    op_a      = rs1_data_i;
                    op_b      = rs2_data_i;
                    is_branch = 1'b1;
                    legal     = 1'b1;
                    case (funct3_i)
                        3'b000:  alu_op = ALU_EQ;
                        3'b001:  alu_op = ALU_NE;
                        3'b100:  alu_op = ALU_LT;
                        3'b101:  alu_op = ALU_GE;
                        3'b110:  alu_op = ALU_LTU;
                        3'b111:  alu_op = ALU_GEU;
                        default: legal  = 1'b0;
                    endcase
                end
`ifdef MGT01_ISSUE_CSR_EN
                OPC_SYSTEM: begin
                    is_csr    = 1'b1;
                    writes_rd = 1'b1;
                    legal     = 1'b1;
                    case (funct3_i[1:0])
                        2'b01: csr_direct = 1'b1;
                        2'b10: begin alu_op = ALU_OR;   op_a = csr_src; op_b = csr_data_i; end
                        2'b11: begin alu_op = ALU_BMSK; op_a = csr_src; op_b = csr_data_i; end
                        default: legal = 1'b0;
                    endcase
                end
`endif
                default: legal = 1'b0;
            endcase
        end
    end

    assign alu_op_A_o = data_u'(op_a);
    assign alu_op_B_o = data_u'(op_b);
    assign alu_ops_o  = alu_op;

    // Dedicated target adder keeps the ALU free to compute the link address.
    assign tgt_base = (opcode_i == OPC_JALR) ? rs1_data_i : pc_i;
    assign tgt_sum  = tgt_base + imm_i;

    always_comb begin
        wb_in         = '0;
        wb_in.result  = is_csr  ? csr_data_i :
                        use_cmp ? {{(XLEN-1){1'b0}}, alu_comparison_i} : alu_result_i;
        wb_in.rd      = rd_addr_i;
        wb_in.wr_en   = legal && writes_rd && (rd_addr_i != 5'd0);
        wb_in.taken   = legal && (is_jump || (is_branch && alu_comparison_i));
        wb_in.target  = (is_jump || is_branch) ?
                        {tgt_sum[XLEN-1:1], tgt_sum[0] & (opcode_i != OPC_JALR)} : '0;
`ifdef MGT01_ISSUE_CSR_EN
        wb_in.csr_wdata = is_csr ? (csr_direct ? csr_src : alu_result_i) : '0;
        wb_in.csr_we    = legal && is_csr;
`else
        wb_in.csr_wdata = '0;
        wb_in.csr_we    = 1'b0;
`endif
        wb_in.illegal = valid_i && !legal;
    end

    mgt01_issue_skid #(.T(wb_bundle_t)) u_skid (
        .clk       (clk_i),
        .rst       (rst_i),
        .flush     (flush_i),
        .in_valid  (valid_i),
        .in_ready  (ready_o),
        .in_data   (wb_in),
        .out_valid (out_valid),
        .out_ready (ready_i),
        .out_data  (wb_out)
    );

    assign valid_o         = out_valid;
    assign result_o        = wb_out.result;
    assign rd_addr_o       = wb_out.rd;
    assign wr_en_o         = out_valid && wb_out.wr_en;
    assign branch_taken_o  = out_valid && wb_out.taken;
    assign branch_target_o = wb_out.target;
    assign csr_wdata_o     = wb_out.csr_wdata;
    assign csr_we_o        = out_valid && wb_out.csr_we;
    assign illegal_o       = out_valid && wb_out.illegal;

endmodule

// File: doc/mgt01_alu_issue.md
# mgt01_alu_issue

Execute-stage issue/writeback sequencer for the MicroGT-01 integer pipeline. It accepts decoded RV32I instructions from decode over a valid/ready handshake and drives the combinational ALU's operand and operation inputs. In the same cycle it captures the ALU result and comparison flag into an output register with a skid buffer, then presents a writeback/branch bundle to the next stage.

## Interface
- XLEN, 32: datapath width; only 32 is supported.
- clk_i  in  1  core clock; all state updates on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- flush_i  in  1  kill all buffered and incoming instructions this cycle.
- valid_i / ready_o  in/out  1  upstream handshake; transfer when both are high.
- opcode_i  in  7, funct3_i  in  3, funct7_i  in  7  decoded instruction fields.
- rs1_data_i, rs2_data_i, imm_i, pc_i, csr_data_i  in  32  operands, sign-extended immediate, instruction PC, current CSR value.
- rd_addr_i  in  5  destination register.
- alu_op_A_o, alu_op_B_o  out  32 (data_u)  ALU operands.
- alu_ops_o  out  alu_ops_e  ALU operation.
- alu_result_i  in  32, alu_comparison_i  in  1  ALU outputs.
- valid_o / ready_i  out/in  1  downstream handshake.
- result_o  out  32  rd write data.
- rd_addr_o  out  5, wr_en_o  out  1  rd write enable (0 for rd=x0, branches, illegal).
- branch_taken_o  out  1, branch_target_o  out  32  redirect for branches/jumps.
- csr_wdata_o  out  32, csr_we_o  out  1  CSR write data and enable.
- illegal_o  out  1  unsupported opcode/funct combination.

## Operation
- Decoding is combinational from the upstream inputs. The ALU drive is valid only when valid_i is high; otherwise the block drives ALU_ADD with 0/0.
- OP / OP-IMM:
  - op_A = rs1; op_B = rs2 or imm.
  - funct7[5] selects SUB over ADD for OP only, and SRA over SRL for both OP and OP-IMM.
  - For shifts, op_B is masked to bits [4:0].
- SLT / SLTU: drive ALU_LT / ALU_LTU; result = {31'b0, alu_comparison_i}.
- LUI: ADD with 0 and imm. AUIPC: ADD with pc and imm.
- JAL / JALR:
  - ADD with pc and 4.
  - branch_taken = 1.
  - Target from an internal adder: pc+imm for JAL; (rs1+imm) & ~1 for JALR.
- BRANCH:
  - funct3 maps to ALU_EQ/NE/LT/GE/LTU/GEU with op_A = rs1, op_B = rs2.
  - branch_taken = alu_comparison_i; target = pc+imm.
- CSR (see Configuration):
  - result = csr_data_i; csr_we = 1.
  - CSRRW: csr_wdata = rs1.
  - CSRRS: ALU_OR of rs1 and csr.
  - CSRRC: ALU_BMSK with op_A = rs1, op_B = csr.
- Any other opcode/funct: illegal_o = 1 and all write enables = 0. The instruction still flows through the handshake.
- Buffer state machine:
  - States: EMPTY, ONE (output register valid), FULL (output register plus skid valid).
  - ready_o = (state != FULL) && !rst_i.
  - EMPTY + accept → ONE.
  - ONE + accept with no downstream take → FULL (captured into skid).
  - ONE + take with no accept → EMPTY.
  - ONE + take + accept → ONE (output register reloaded).
  - FULL + take → ONE (skid moves to output register). No accept is possible in FULL.
- Ordering is strictly FIFO.

## Timing
- Latency: 1 cycle. An instruction accepted at edge N appears on valid_o after edge N.
- The ALU path is combinational within the accept cycle; alu_*_i is sampled on the accept edge.
- Reset (rst_i high at an edge):
  - State returns to EMPTY.
  - valid_o, wr_en_o, branch_taken_o, csr_we_o, illegal_o = 0.
  - result_o, rd_addr_o, branch_target_o, csr_wdata_o = 0.
  - ready_o = 0 while rst_i is high.
  - Reset mid-transfer drops all in-flight data.
- flush_i:
  - Clears both entries to EMPTY at the next edge.
  - Blocks acceptance of valid_i in the same cycle.
  - Flush overrides take and accept; reset overrides flush.
- Outputs are held stable while valid_o && !ready_i.

## Configuration
- MGT01_ISSUE_CSR_EN defined: SYSTEM-opcode CSR instructions (funct3 001/010/011) are decoded as above, including immediate variants (rs1 replaced by zero-extended imm[4:0]).
- MGT01_ISSUE_CSR_EN undefined:
  - All SYSTEM opcodes raise illegal_o; csr_we_o is tied to 0.
  - csr_wdata_o is tied to 0, and the ALU_BMSK path is never driven.

## Structure
- Shared package holds:
  - RV32I opcode constants (OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH, SYSTEM).
  - The issue_state_e enum (EMPTY/ONE/FULL).
  - The packed wb_bundle_t struct (result, rd, wr_en, taken, target, csr_wdata, csr_we, illegal).
- Sub-module mgt01_issue_skid: a generic 2-entry valid/ready skid register parameterized on wb_bundle_t. The decode/ALU drive logic stays in the top module.

## Test plan
- ADDI rs1=5, imm=-3, rd=7 → one cycle later: valid_o=1, result_o=2, rd_addr_o=7, wr_en_o=1.
- BLTU rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20 → branch_taken_o=0. BLT with the same operands → branch_taken_o=1, branch_target_o=0x120, wr_en_o=0.
- SLL rs1=1, rs2=0x21 → result_o=2 (shift masked to 1). SRA of 0x80000000 by 4 → result_o=0xF8000000.
- Backpressure:
  - Stimulus: three back-to-back ADDs with ready_i=0 for 3 cycles.
  - Required: ready_o drops after the 2nd accept; the 3rd is held upstream; all three emerge in order once ready_i=1.
- CSRRC with csr_data=0xFF, rs1=0x0F → result_o=0xFF, csr_wdata_o=0xF0, csr_we_o=1. With the macro undefined → illegal_o=1, csr_we_o=0.
- State FULL, then flush_i pulse → valid_o=0 next cycle, ready_o=1. rst_i asserted in ONE → all outputs 0, ready_o=0 during reset.
